// File: rtl/int0_issue_queue.sv
// int0_issue_queue: collapsing data-capture issue queue feeding the int0 ALU/MUL execute stage.
// Define INT0_IQ_WAKEUP_BYPASS_EN to let a broadcast wake and select an entry in the same cycle.
package common;
    localparam int PRF_WIDTH = 6;
    localparam int ROB_WIDTH = 4;
    typedef struct packed {
        logic       is_mul;
        logic [3:0] op;
    } control_type;
endpackage

module int0_issue_queue
    import common::*;
#(
    parameter int DEPTH    = 8,
    parameter int WB_PORTS = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush_valid,
    input  logic [ROB_WIDTH:0]   flush_robid,
    input  logic                 disp_valid,
    output logic                 disp_ready,
    input  logic [31:0]          disp_pc,
    input  control_type          disp_control,
    input  logic                 disp_rs1_rdy,
    input  logic                 disp_rs2_rdy,
    input  logic [PRF_WIDTH-1:0] disp_rs1_tag,
    input  logic [PRF_WIDTH-1:0] disp_rs2_tag,
    input  logic [31:0]          disp_rs1_data,
    input  logic [31:0]          disp_rs2_data,
    input  logic [PRF_WIDTH-1:0] disp_T,
    input  logic [ROB_WIDTH:0]   disp_robid,
    input  logic [WB_PORTS-1:0]  wb_valid,
    input  logic [WB_PORTS-1:0]  wb_need_to_wb,
    input  logic [PRF_WIDTH-1:0] wb_prd [WB_PORTS],
    input  logic [31:0]          wb_data [WB_PORTS],
    input  logic                 mul_slot_busy,
    output logic                 int0_valid,
    output logic [31:0]          int0_pc,
    output control_type          int0_control,
    output logic [31:0]          int0_rs1,
    output logic [31:0]          int0_rs2,
    output logic [PRF_WIDTH-1:0] int0_T,
    output logic [ROB_WIDTH:0]   int0_robid
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    typedef struct packed {
        logic                 valid;
        logic [31:0]          pc;
        control_type          control;
        logic                 rdy1;
        logic [PRF_WIDTH-1:0] tag1;
        logic [31:0]          data1;
        logic                 rdy2;
        logic [PRF_WIDTH-1:0] tag2;
        logic [31:0]          data2;
        logic [PRF_WIDTH-1:0] T;
        logic [ROB_WIDTH:0]   robid;
    } entry_t;

    entry_t        q   [DEPTH];
    entry_t        w   [DEPTH];
    entry_t        src [DEPTH];
    entry_t        nq  [DEPTH];
    entry_t        d_e;
    entry_t        d_w;
    logic [CW-1:0] count;
    logic [CW-1:0] kept;
    logic [CW-1:0] count_n;
    logic [IW-1:0] sel_idx;
    logic          sel_valid;
    logic          accept;

    function automatic entry_t wake(input entry_t e);
        entry_t r;
        r = e;
        for (int k = 0; k < WB_PORTS; k++) begin
            if (wb_valid[k] && wb_need_to_wb[k] && !e.rdy1 && wb_prd[k] == e.tag1) begin
                r.rdy1  = 1'b1;
                r.data1 = wb_data[k];
            end
            if (wb_valid[k] && wb_need_to_wb[k] && !e.rdy2 && wb_prd[k] == e.tag2) begin
                r.rdy2  = 1'b1;
                r.data2 = wb_data[k];
            end
        end
        return r;
    endfunction

    // Wrap bit flips the sense of the low-bit compare across a ROB wrap.
    function automatic logic killed(input logic [ROB_WIDTH:0] r);
        return flush_valid & (r[ROB_WIDTH] ^ flush_robid[ROB_WIDTH] ^
                              (r[ROB_WIDTH-1:0] > flush_robid[ROB_WIDTH-1:0]));
    endfunction

    function automatic logic eligible(input entry_t e);
        return e.valid & e.rdy1 & e.rdy2 &
               (~e.control.is_mul | ~(mul_slot_busy | (int0_valid & int0_control.is_mul)));
    endfunction

    assign disp_ready = (count < CW'(DEPTH)) & ~flush_valid;
    assign accept     = disp_valid & disp_ready;

    always_comb begin
        d_e = '{valid: 1'b1, pc: disp_pc, control: disp_control,
                rdy1: disp_rs1_rdy, tag1: disp_rs1_tag, data1: disp_rs1_data,
                rdy2: disp_rs2_rdy, tag2: disp_rs2_tag, data2: disp_rs2_data,
                T: disp_T, robid: disp_robid};
        d_w = wake(d_e);
        for (int i = 0; i < DEPTH; i++) w[i] = wake(q[i]);
    end

`ifdef INT0_IQ_WAKEUP_BYPASS_EN
    assign src = w;
`else
    assign src = q;
`endif

    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!flush_valid && eligible(src[i])) begin
                sel_valid = 1'b1;
                sel_idx   = IW'(i);
            end
        end
    end

    // Survivors slide down in order; the accepted dispatch lands just past them.
    always_comb begin
        kept = '0;
        for (int i = 0; i < DEPTH; i++) nq[i] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q[i].valid && !(sel_valid && sel_idx == IW'(i)) && !killed(q[i].robid)) begin
                nq[kept[IW-1:0]] = w[i];
                kept = kept + CW'(1);
            end
        end
        if (accept) nq[kept[IW-1:0]] = d_w;
        count_n = kept + CW'(accept);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count        <= '0;
            q            <= '{default: '0};
            int0_valid   <= 1'b0;
            int0_pc      <= '0;
            int0_control <= '0;
            int0_rs1     <= '0;
            int0_rs2     <= '0;
            int0_T       <= '0;
            int0_robid   <= '0;
        end else begin
            count      <= count_n;
            q          <= nq;
            int0_valid <= sel_valid;
            if (sel_valid) begin
                int0_pc      <= src[sel_idx].pc;
                int0_control <= src[sel_idx].control;
                int0_rs1     <= src[sel_idx].data1;
                int0_rs2     <= src[sel_idx].data2;
                int0_T       <= src[sel_idx].T;
                int0_robid   <= src[sel_idx].robid;
            end
        end
    end
endmodule
